// File: rtl/sym_tx_pkg.sv
// sym_tx_pkg: state encoding, next-state and output functions of the driven 8-state symbol FSM
package sym_tx_pkg;
  typedef enum logic [2:0] {ST0, ST1, ST2, ST3, ST4, ST5, ST6, ST3_ALT} st_e;
  function automatic st_e next_st(input st_e s, input logic [1:0] a);
    case (s)
      ST0: next_st = a == 2'b01 ? ST2 : a == 2'b11 ? ST5 : ST1;
      ST1: next_st = a[1] ? ST3 : ST2;
      ST2: next_st = a == 2'b00 ? ST0 : a == 2'b01 ? ST4 : a == 2'b10 ? ST3_ALT : ST3;
      ST3: next_st = a == 2'b11 ? ST5 : ST2;
      ST4: next_st = a == 2'b01 ? ST3 : a == 2'b11 ? ST5 : ST2;
      ST5: next_st = a == 2'b00 ? ST0 : a == 2'b11 ? ST6 : ST3;
      ST6: next_st = a == 2'b00 ? ST0 : ST3;
      default: next_st = a[0] ? ST3 : ST1;
    endcase
  endfunction
  // the alternate state is indistinguishable from ST3 at the FSM output
  function automatic logic [2:0] st_out(input st_e s);
    return s == ST3_ALT ? 3'd3 : s;
  endfunction
endpackage

// File: rtl/sym_tx_fifo.sv
// sym_fifo: power-of-two circular symbol buffer; caller guarantees no push when full without pop
module sym_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [1:0] sym_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       last_o,
  output logic [1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(push_i);
      rp_q  <= rp_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wp_q] <= sym_i;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign last_o  = cnt_q == (AW+1)'(1);
  assign head_o  = mem_q[rp_q];
endmodule

// File: rtl/sym_tx.sv
// sym_tx: buffers symbols, plays each for HOLD clocks into an FSM and checks its output against a model
module sym_tx import sym_tx_pkg::*; #(
  parameter int         DEPTH    = 16,
  parameter int         HOLD     = 4,
  parameter logic [1:0] IDLE_SYM = 2'b00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_sym,
  input  logic       start,
  input  logic [2:0] saida_in,
  output logic [1:0] a,
  output logic       full,
  output logic       busy,
  output logic       done,
  output logic [2:0] exp_state,
  output logic       err,
  output logic [3:0] err_cnt
);
  logic play_q, done_q, arm_q, err_q;
  logic [3:0] hold_q, cnt_q;
  st_e st_q;
  logic push, pop, fin, mismatch, empty, last;
  logic [1:0] head;
  sym_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push_i(push), .pop_i(pop), .sym_i(wr_sym),
    .full_o(full), .empty_o(empty), .last_o(last), .head_o(head)
  );
  assign pop      = play_q && hold_q == 4'(HOLD - 1);
  assign push     = wr_en && (!full || pop);
  // a write landing on the final pop keeps the run going
  assign fin      = pop && last && !push;
  assign mismatch = arm_q && saida_in != st_out(st_q);
  assign a        = play_q ? head : IDLE_SYM;
  always_ff @(posedge clk) begin
    if (reset) begin
      play_q <= 1'b0;
      hold_q <= '0;
      done_q <= 1'b0;
      st_q   <= ST0;
      arm_q  <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      play_q <= play_q ? !fin : start && !empty;
      hold_q <= (!play_q || pop) ? 4'd0 : hold_q + 4'd1;
      done_q <= fin;
      st_q   <= next_st(st_q, a);
      arm_q  <= 1'b1;
      err_q  <= err_q || mismatch;
      cnt_q  <= cnt_q + 4'(mismatch && cnt_q != 4'd15);
    end
  end
  assign busy      = play_q;
  assign done      = done_q;
  assign exp_state = st_q;
  assign err       = err_q;
  assign err_cnt   = cnt_q;
endmodule

// File: tb/tb_sym_tx.sv
// tb_sym_tx: directed vector table plus multi-cycle sequences for sym_tx
module tb_sym_tx;
  logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0, force_z = 1'b0;
  logic [1:0] wr_sym = 2'b00;
  logic [2:0] saida_in, fsm_q;
  logic [1:0] a;
  logic full, busy, done, err;
  logic [2:0] exp_state;
  logic [3:0] err_cnt;
  int nvec = 0, nerr = 0;
  logic [1:0] q[$];
  int nxt_t [32] = '{1,2,1,5, 2,2,3,3, 0,4,7,3, 2,2,2,5, 2,3,2,5, 0,3,3,6, 0,3,3,3, 1,3,1,3};
  typedef struct {int wr, sym, st, a, busy, full, done, es, err;} vec_t;
  vec_t vt [18];

  sym_tx dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sym(wr_sym), .start(start),
    .saida_in(saida_in), .a(a), .full(full), .busy(busy), .done(done),
    .exp_state(exp_state), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) fsm_q <= reset ? 3'd0 : 3'(nxt_t[{fsm_q, a}]);
  assign saida_in = force_z ? 3'd0 : (fsm_q == 3'd7 ? 3'd3 : fsm_q);

  task automatic chk(input string nm, input int act, input int exp_v);
    nvec++;
    if (act != exp_v) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_dut();
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; force_z = 1'b0;
    cyc(); cyc();
    chk("rst_a", a, 0); chk("rst_full", full, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_state", exp_state, 0);
    chk("rst_err", err, 0); chk("rst_cnt", err_cnt, 0);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [1:0] s);
    wr_en = 1'b1; wr_sym = s;
    cyc();
    wr_en = 1'b0;
  endtask

  // plays n queued symbols; optional writes on cycles c1/c2; full expected at play cycle 4
  task automatic play(input int n, input int c1, input logic [1:0] s1,
                      input int c2, input logic [1:0] s2, input int full4);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < n * 4; i++) begin
      chk("play_a", a, q[i / 4]);
      chk("play_busy", busy, 1);
      chk("play_done", done, 0);
      chk("play_state", exp_state, fsm_q);
      if (i == 4) chk("play_full4", full, full4);
      wr_en = (i == c1) || (i == c2);
      wr_sym = (i == c1) ? s1 : s2;
      cyc();
    end
    wr_en = 1'b0;
    chk("end_done", done, 1); chk("end_busy", busy, 0); chk("end_a", a, 0);
    cyc();
    chk("post_done", done, 0);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) vt[i] = '{0,0,0, 0,0,0,0, (i % 3 == 0) ? 1 : (i % 3 == 1) ? 2 : 0, 0};
    vt[6]  = '{1,1,0, 0,0,0,0, 1,0};
    vt[7]  = '{1,2,0, 0,0,0,0, 2,0};
    vt[8]  = '{0,0,1, 1,1,0,0, 0,0};
    vt[9]  = '{0,0,0, 1,1,0,0, 2,0};
    vt[10] = '{0,0,1, 1,1,0,0, 4,0};
    vt[11] = '{0,0,0, 1,1,0,0, 3,0};
    vt[12] = '{0,0,0, 2,1,0,0, 2,0};
    vt[13] = '{0,0,0, 2,1,0,0, 7,0};
    vt[14] = '{0,0,0, 2,1,0,0, 1,0};
    vt[15] = '{0,0,0, 2,1,0,0, 3,0};
    vt[16] = '{0,0,1, 0,0,0,1, 2,0};
    vt[17] = '{0,0,1, 0,0,0,0, 0,0};
    @(negedge clk);
    rst_dut();
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'(vt[i].wr); wr_sym = 2'(vt[i].sym); start = 1'(vt[i].st);
      cyc();
      chk($sformatf("v%0d_a", i), a, vt[i].a);
      chk($sformatf("v%0d_busy", i), busy, vt[i].busy);
      chk($sformatf("v%0d_full", i), full, vt[i].full);
      chk($sformatf("v%0d_done", i), done, vt[i].done);
      chk($sformatf("v%0d_state", i), exp_state, vt[i].es);
      chk($sformatf("v%0d_err", i), err, vt[i].err);
    end
    wr_en = 1'b0; start = 1'b0;
    // nine-symbol run, 36 play cycles
    q = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3};
    foreach (q[i]) wr(q[i]);
    play(9, -1, 2'd0, -1, 2'd0, 0);
    chk("run9_err", err, 0);
    // seventeenth write into a full buffer is dropped
    rst_dut();
    q.delete();
    for (int i = 0; i < 17; i++) begin
      wr(2'(i % 4));
      if (i < 16) q.push_back(2'(i % 4));
      chk($sformatf("fill%0d_full", i + 1), full, (i >= 15) ? 1 : 0);
    end
    play(16, -1, 2'd0, -1, 2'd0, 0);
    chk("fill_err", err, 0);
    // full buffer: write without pop dropped, write on the pop cycle accepted
    rst_dut();
    q.delete();
    for (int i = 0; i < 16; i++) begin
      wr(2'(i % 4));
      q.push_back(2'(i % 4));
    end
    q.push_back(2'd2);
    play(17, 1, 2'd3, 3, 2'd2, 1);
    chk("popwr_err", err, 0);
    // forced-zero FSM output saturates the mismatch counter
    rst_dut();
    wr(2'd3); wr(2'd3); wr(2'd3);
    force_z = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 19; i++) cyc();
    chk("force_err", err, 1);
    chk("force_cnt", err_cnt, 15);
    force_z = 1'b0;
    cyc(); cyc();
    chk("sticky_err", err, 1);
    chk("sticky_cnt", err_cnt, 15);
    // reset in the third symbol aborts playback without done
    rst_dut();
    wr(2'd1); wr(2'd2); wr(2'd3); wr(2'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 9; i++) cyc();
    chk("mid_a", a, 3);
    reset = 1'b1;
    cyc();
    chk("abort_busy", busy, 0); chk("abort_a", a, 0);
    chk("abort_state", exp_state, 0); chk("abort_done", done, 0);
    chk("abort_full", full, 0);
    reset = 1'b0; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      start = 1'b0;
      chk("after_done", done, 0);
      chk("after_busy", busy, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
